branch_predictor_btb: RTL and testbench

- Parametrised, stateful successor to the combinational branch decision unit.
- Holds a direct-mapped branch target buffer (BTB), with a tag, target, jump flag and 2-bit saturating counter per entry.
- Fetch side: gives a same-cycle prediction for the fetch PC.
- Execute side: resolves branches/jumps, trains the table, and issues a registered flush / next-PC select on misprediction.
- Sits between the PC-select mux in IF and the branch-resolve logic in EX.

---
 rtl/btb_if.sv | 61 ++++++
 rtl/branch_predictor_btb.sv | 169 ++++++++++++++++
 tb/tb_branch_predictor_btb.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/btb_if.sv
// Fetch/resolve bundle between the IF/EX pipeline and the BTB predictor.
// BTB_STATS_EN adds the LookupCount/MispredCount statistics signals.
interface btb_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] FetchPC;
  logic              PcMatchValid;
  logic              PredTaken;
  logic [ADDR_W-1:0] PredTarget;
  logic              ResValid;
  logic              BranchInstr;
  logic              JumpInstr;
  logic [ADDR_W-1:0] ResPC;
  logic              ResTaken;
  logic [ADDR_W-1:0] ResTarget;
  logic              PredTakenIn;
  logic [ADDR_W-1:0] PredTargetIn;
  logic              Clear;
  logic              FlushPipePC;
  logic [1:0]        NPC;
  logic [ADDR_W-1:0] CorrPC;
  logic              Busy;
`ifdef BTB_STATS_EN
  logic [31:0]       LookupCount;
  logic [31:0]       MispredCount;

  modport master (
    output FetchPC, ResValid, BranchInstr, JumpInstr,
    output ResPC, ResTaken, ResTarget,
    output PredTakenIn, PredTargetIn, Clear,
    input  PcMatchValid, PredTaken, PredTarget,
    input  FlushPipePC, NPC, CorrPC, Busy,
    input  LookupCount, MispredCount
  );

  modport slave (
    input  FetchPC, ResValid, BranchInstr, JumpInstr,
    input  ResPC, ResTaken, ResTarget,
    input  PredTakenIn, PredTargetIn, Clear,
    output PcMatchValid, PredTaken, PredTarget,
    output FlushPipePC, NPC, CorrPC, Busy,
    output LookupCount, MispredCount
  );
`else
  modport master (
    output FetchPC, ResValid, BranchInstr, JumpInstr,
    output ResPC, ResTaken, ResTarget,
    output PredTakenIn, PredTargetIn, Clear,
    input  PcMatchValid, PredTaken, PredTarget,
    input  FlushPipePC, NPC, CorrPC, Busy
  );

  modport slave (
    input  FetchPC, ResValid, BranchInstr, JumpInstr,
    input  ResPC, ResTaken, ResTarget,
    input  PredTakenIn, PredTargetIn, Clear,
    output PcMatchValid, PredTaken, PredTarget,
    output FlushPipePC, NPC, CorrPC, Busy
  );
`endif
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit counters, registered mispredict flush.
// Optional BTB_STATS_EN adds saturating lookup/mispredict counters.
module branch_predictor_btb #(
  parameter int          ADDR_W   = 32,
  parameter int          ENTRIES  = 16,
  localparam int         INDEX_W  = $clog2(ENTRIES),
  parameter logic [1:0]  CTR_INIT = 2'b10
) (
  input logic   clk,
  input logic   rst_n,
  btb_if.slave  bus
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam logic [ADDR_W-1:0]  FOUR = ADDR_W'(4);
  localparam logic [INDEX_W-1:0] ONE  = INDEX_W'(1);
  localparam logic [INDEX_W-1:0] LAST = INDEX_W'(ENTRIES - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state;
  logic               busy;
  logic [INDEX_W-1:0] ptr;

  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] is_jump;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [INDEX_W-1:0] f_idx;
  logic [TAG_W-1:0]   f_tag;
  logic               f_hit;
  logic               f_taken;

  assign f_idx   = bus.FetchPC[INDEX_W+1:2];
  assign f_tag   = bus.FetchPC[ADDR_W-1:INDEX_W+2];
  assign f_hit   = valid[f_idx] && (tag_q[f_idx] == f_tag) && !busy;
  assign f_taken = f_hit && (is_jump[f_idx] || ctr_q[f_idx][1]);

  assign bus.PcMatchValid = f_hit;
  assign bus.PredTaken    = f_taken;
  assign bus.PredTarget   = f_taken ? target_q[f_idx]
                                    : bus.FetchPC + FOUR;
  assign bus.Busy         = busy;

  logic [INDEX_W-1:0] r_idx;
  logic [TAG_W-1:0]   r_tag;
  logic               res_evt;
  logic               taken;
  logic               mispred;
  logic               r_hit;
  logic               alloc;
  logic               upd;
  logic [1:0]         ctr_nx;

  assign r_idx   = bus.ResPC[INDEX_W+1:2];
  assign r_tag   = bus.ResPC[ADDR_W-1:INDEX_W+2];
  assign res_evt = bus.ResValid && (bus.BranchInstr || bus.JumpInstr);
  assign taken   = bus.JumpInstr || bus.ResTaken;
  assign mispred = (taken != bus.PredTakenIn) ||
                   (taken && (bus.PredTargetIn != bus.ResTarget));
  assign r_hit   = valid[r_idx] && (tag_q[r_idx] == r_tag);
  assign alloc   = res_evt && !busy && !r_hit && taken;
  assign upd     = res_evt && !busy && r_hit;

  always_comb begin
    ctr_nx = ctr_q[r_idx];
    if (taken) begin
      if (ctr_nx != 2'b11) ctr_nx = ctr_nx + 2'b01;
    end else begin
      if (ctr_nx != 2'b00) ctr_nx = ctr_nx - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      ptr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.Clear) begin
            state <= SWEEP;
            busy  <= 1'b1;
            ptr   <= '0;
          end
        end
        SWEEP: begin
          ptr <= ptr + ONE;
          if (ptr == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (busy) begin
      valid[ptr] <= 1'b0;
    end else if (alloc) begin
      valid[r_idx] <= 1'b1;
    end
  end

  // Payload fields are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_q[r_idx]    <= r_tag;
      target_q[r_idx] <= bus.ResTarget;
      is_jump[r_idx]  <= bus.JumpInstr;
      ctr_q[r_idx]    <= CTR_INIT;
    end else if (upd) begin
      ctr_q[r_idx]   <= ctr_nx;
      is_jump[r_idx] <= bus.JumpInstr;
      if (taken) target_q[r_idx] <= bus.ResTarget;
    end
  end

  logic              flush_q;
  logic [1:0]        npc_q;
  logic [ADDR_W-1:0] corr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_q <= 1'b0;
      npc_q   <= 2'b00;
      corr_q  <= '0;
    end else begin
      flush_q <= res_evt && mispred;
      if (res_evt && mispred) begin
        npc_q  <= taken ? 2'b01 : 2'b10;
        corr_q <= taken ? bus.ResTarget : bus.ResPC + FOUR;
      end else begin
        npc_q <= 2'b00;
      end
    end
  end

  assign bus.FlushPipePC = flush_q;
  assign bus.NPC         = npc_q;
  assign bus.CorrPC      = corr_q;

`ifdef BTB_STATS_EN
  logic [31:0] lookup_cnt;
  logic [31:0] mispred_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lookup_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (f_hit && lookup_cnt != 32'hFFFF_FFFF)
        lookup_cnt <= lookup_cnt + 32'd1;
      if (res_evt && mispred && mispred_cnt != 32'hFFFF_FFFF)
        mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  assign bus.LookupCount  = lookup_cnt;
  assign bus.MispredCount = mispred_cnt;
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb (ENTRIES=16, ADDR_W=32).
module tb_branch_predictor_btb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btb_if #(.ADDR_W(32)) bus();

  branch_predictor_btb #(
    .ADDR_W(32),
    .ENTRIES(16),
    .CTR_INIT(2'b10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int vecs = 0;
  int errs = 0;
  int nbusy;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    bus.FetchPC = pc;
    #1;
  endtask

  task automatic resolve(input logic br, input logic jp,
                         input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic ptk,
                         input logic [31:0] ptgt);
    bus.ResValid     = 1'b1;
    bus.BranchInstr  = br;
    bus.JumpInstr    = jp;
    bus.ResPC        = pc;
    bus.ResTaken     = tk;
    bus.ResTarget    = tgt;
    bus.PredTakenIn  = ptk;
    bus.PredTargetIn = ptgt;
    tick();
    bus.ResValid    = 1'b0;
    bus.BranchInstr = 1'b0;
    bus.JumpInstr   = 1'b0;
  endtask

  task automatic corr(input string tag, input logic f,
                      input logic [1:0] n, input logic [31:0] c);
    chk({tag, "_flush"}, 32'(bus.FlushPipePC), 32'(f));
    chk({tag, "_npc"}, 32'(bus.NPC), 32'(n));
    chk({tag, "_corr"}, bus.CorrPC, c);
  endtask

  initial begin
    bus.FetchPC      = '0;
    bus.ResValid     = 1'b0;
    bus.BranchInstr  = 1'b0;
    bus.JumpInstr    = 1'b0;
    bus.ResPC        = '0;
    bus.ResTaken     = 1'b0;
    bus.ResTarget    = '0;
    bus.PredTakenIn  = 1'b0;
    bus.PredTargetIn = '0;
    bus.Clear        = 1'b0;

    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    look(32'h100);
    chk("rst_hit", 32'(bus.PcMatchValid), 32'd0);
    chk("rst_ptk", 32'(bus.PredTaken), 32'd0);
    chk("rst_ptgt", bus.PredTarget, 32'h104);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    corr("rst", 1'b0, 2'b00, 32'h0);

    // Allocate 0x100 -> 0x200, lookup in the same cycle sees the old table
    bus.ResValid = 1'b1; bus.BranchInstr = 1'b1; bus.ResPC = 32'h100;
    #1;
    chk("same_cyc_miss", 32'(bus.PcMatchValid), 32'd0);
    resolve(1, 0, 32'h100, 1, 32'h200, 0, 32'h0);
    corr("alloc", 1'b1, 2'b01, 32'h200);
    look(32'h100);
    chk("alloc_hit", 32'(bus.PcMatchValid), 32'd1);
    chk("alloc_ptk", 32'(bus.PredTaken), 32'd1);
    chk("alloc_ptgt", bus.PredTarget, 32'h200);
    tick();
    corr("idle", 1'b0, 2'b00, 32'h200);

    // Counter 10 -> 01 (flush) -> 00 (no flush)
    resolve(1, 0, 32'h100, 0, 32'h200, 1, 32'h200);
    corr("nt1", 1'b1, 2'b10, 32'h104);
    look(32'h100);
    chk("nt1_ptk", 32'(bus.PredTaken), 32'd0);
    chk("nt1_ptgt", bus.PredTarget, 32'h104);
    resolve(1, 0, 32'h100, 0, 32'h200, 0, 32'h0);
    corr("nt2", 1'b0, 2'b00, 32'h104);
    resolve(1, 0, 32'h100, 0, 32'h200, 0, 32'h0);
    resolve(1, 0, 32'h100, 0, 32'h200, 0, 32'h0);
    corr("nt4", 1'b0, 2'b00, 32'h104);
    // 00 + taken = 01 still predicts not-taken; underflow would not
    resolve(1, 0, 32'h100, 1, 32'h200, 0, 32'h0);
    corr("t_after_sat", 1'b1, 2'b01, 32'h200);
    look(32'h100);
    chk("sat_ptk", 32'(bus.PredTaken), 32'd0);
    resolve(1, 0, 32'h100, 1, 32'h200, 0, 32'h0);
    look(32'h100);
    chk("ctr10_ptk", 32'(bus.PredTaken), 32'd1);

    // Jump at 0x300 (aliases index 0) with ResTaken=0 on the port
    resolve(0, 1, 32'h300, 0, 32'h40, 0, 32'h0);
    corr("jmp", 1'b1, 2'b01, 32'h40);
    look(32'h300);
    chk("jmp_hit", 32'(bus.PcMatchValid), 32'd1);
    chk("jmp_ptgt", bus.PredTarget, 32'h40);
    look(32'h100);
    chk("jmp_evict", 32'(bus.PcMatchValid), 32'd0);
    resolve(1, 0, 32'h300, 0, 32'h40, 1, 32'h40);
    corr("jnt", 1'b1, 2'b10, 32'h304);
    resolve(1, 0, 32'h300, 0, 32'h40, 0, 32'h0);
    // Counter now 01; jump bit alone must force taken
    resolve(0, 1, 32'h300, 0, 32'h40, 0, 32'h0);
    look(32'h300);
    chk("jmp_force_ptk", 32'(bus.PredTaken), 32'd1);
    chk("jmp_force_tgt", bus.PredTarget, 32'h40);

    // Fill more entries, then sweep
    resolve(1, 0, 32'h104, 1, 32'h500, 0, 32'h0);
    resolve(1, 0, 32'h108, 1, 32'h508, 0, 32'h0);
    look(32'h104);
    chk("fill_hit", 32'(bus.PcMatchValid), 32'd1);
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 0) begin
        look(32'h300);
        chk("sweep_miss", 32'(bus.PcMatchValid), 32'd0);
        chk("sweep_ptk", 32'(bus.PredTaken), 32'd0);
        bus.ResValid = 1'b1; bus.BranchInstr = 1'b1;
        bus.ResPC = 32'h10C; bus.ResTaken = 1'b1;
        bus.ResTarget = 32'h600; bus.PredTakenIn = 1'b0;
        bus.Clear = 1'b1;
      end
      if (i == 1) begin
        bus.ResValid = 1'b0; bus.BranchInstr = 1'b0;
        bus.Clear = 1'b0;
        corr("sweep_flush", 1'b1, 2'b01, 32'h600);
      end
      if (bus.Busy) nbusy++;
      tick();
    end
    chk("busy_cycles", 32'(nbusy), 32'd16);
    look(32'h10C);
    chk("no_alloc_sweep", 32'(bus.PcMatchValid), 32'd0);
    look(32'h104);
    chk("cleared_104", 32'(bus.PcMatchValid), 32'd0);
    look(32'h300);
    chk("cleared_300", 32'(bus.PcMatchValid), 32'd0);

    // Reset in the middle of a sweep
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    tick();
    tick();
    chk("mid_busy", 32'(bus.Busy), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rst_abort", 32'(bus.Busy), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("rst_idle", 32'(bus.Busy), 32'd0);

    // Aliasing 0x100 / 0x140
    resolve(1, 0, 32'h100, 1, 32'h200, 0, 32'h0);
    look(32'h100);
    chk("alias_a_hit", 32'(bus.PcMatchValid), 32'd1);
    resolve(1, 0, 32'h140, 1, 32'h700, 0, 32'h0);
    corr("alias_flush", 1'b1, 2'b01, 32'h700);
    look(32'h140);
    chk("alias_b_hit", 32'(bus.PcMatchValid), 32'd1);
    chk("alias_b_tgt", bus.PredTarget, 32'h700);
    look(32'h100);
    chk("alias_a_miss", 32'(bus.PcMatchValid), 32'd0);
    chk("alias_a_seq", bus.PredTarget, 32'h104);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
